// File: rtl/digits_scan_ctrl.sv
// Avalon-MM slave holding a 32-bit hex value and scanning it onto a
// common-anode 7-segment bank with dead time, leading-zero blanking and DP control.
module digits_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_W       = 20,
    parameter int DIV_DEFAULT = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] dig_sel_n
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int CNT_W  = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ON
    } state_t;

    // Host-visible registers
    logic [31:0]           value_r;
    logic                  en_r;
    logic                  lzb_r;
    logic [NUM_DIGITS-1:0] dp_r;
    logic [DIV_W-1:0]      div_r;

    // Scan engine
    state_t                state, state_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W-1:0]      on_load;
    logic [15:0]           frame_cnt;
    logic                  snap_ld;
    logic                  frame_inc;

    // Frame snapshot
    logic [31:0]           snap_val;
    logic                  snap_lzb;
    logic [NUM_DIGITS-1:0] snap_dp;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] sel_d;

    logic wr;
    assign wr = chipselect && !write_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_r <= '0;
            en_r    <= 1'b0;
            lzb_r   <= 1'b0;
            dp_r    <= '0;
            div_r   <= DIV_W'(DIV_DEFAULT);
        end else if (wr) begin
            case (address)
                2'd0: value_r <= writedata;
                2'd1: begin
                    en_r  <= writedata[0];
                    lzb_r <= writedata[1];
                    dp_r  <= writedata[8 +: NUM_DIGITS];
                end
                2'd2: div_r <= writedata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = value_r;
            2'd1: begin
                readdata[0]               = en_r;
                readdata[1]               = lzb_r;
                readdata[8 +: NUM_DIGITS] = dp_r;
            end
            2'd2: readdata = 32'(div_r);
            default: begin
                readdata[31:16] = frame_cnt;
                readdata[8]     = (state != IDLE);
                readdata[7:0]   = 8'(idx);
            end
        endcase
    end

    // A zero divider still gives a one-cycle slot
    assign on_load = (div_r == '0) ? '0 : CNT_W'(div_r) - CNT_W'(1);

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        snap_ld   = 1'b0;
        frame_inc = 1'b0;
        if (!en_r) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = DEAD;
                    idx_d   = '0;
                    cnt_d   = DEAD_LOAD;
                    snap_ld = 1'b1;
                end
                DEAD: begin
                    if (cnt == '0) begin
                        state_d = ON;
                        cnt_d   = on_load;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                ON: begin
                    if (cnt == '0) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                        if (idx == LAST_IDX) begin
                            idx_d     = '0;
                            frame_inc = 1'b1;
                            snap_ld   = 1'b1;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pin values are decoded from the next state so the pins register alongside it
    always_comb begin
        upper_zero = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib[i]        = snap_val[4*i +: 4];
            upper_zero[i] = ((snap_val >> (4*i)) == '0);
        end
        seg_d = '1;
        dp_d  = 1'b1;
        sel_d = '1;
        if (state_d == ON) begin
            sel_d[idx_d] = 1'b0;
            dp_d         = ~snap_dp[idx_d];
            if (snap_lzb && (idx_d != '0) && upper_zero[idx_d])
                seg_d = '1;
            else
                seg_d = hex7(nib[idx_d]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
            snap_val  <= '0;
            snap_lzb  <= 1'b0;
            snap_dp   <= '0;
            seg_n     <= '1;
            dp_n      <= 1'b1;
            dig_sel_n <= '1;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            if (frame_inc)
                frame_cnt <= frame_cnt + 16'd1;
            if (snap_ld) begin
                snap_val <= value_r;
                snap_lzb <= lzb_r;
                snap_dp  <= dp_r;
            end
            seg_n     <= seg_d;
            dp_n      <= dp_d;
            dig_sel_n <= sel_d;
        end
    end

endmodule
